// File: rtl/seq_mult_n_if.sv
// Handshake and operand bundle for the sequential multiplier.
// The requester holds the master modport and the multiplier holds the slave modport.
interface seq_mult_n_if #(
   parameter int W = 16
);
   logic           start_i;
   logic           signed_i;
   logic [W-1:0]   a_i;
   logic [W-1:0]   b_i;
   logic           busy_o;
   logic           done_o;
   logic [2*W-1:0] p_o;

   modport master (
      output start_i, signed_i, a_i, b_i,
      input  busy_o, done_o, p_o
   );

   modport slave (
      input  start_i, signed_i, a_i, b_i,
      output busy_o, done_o, p_o
   );
endinterface

// File: rtl/seq_mult_n.sv
// Radix-2 shift-add sequential multiplier giving a full 2W-bit product, unsigned or signed.
// Signed operands are multiplied as magnitudes, and the sign is applied once at the end.
module seq_mult_n #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   seq_mult_n_if.slave  bus
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   mcand;
   logic [W-1:0]   acc;
   logic [W-1:0]   mplier;
   logic           neg;
   logic           busy;
   logic           done;
   logic [2*W-1:0] p;
   logic [W:0]     sum;
   logic [2*W-1:0] full;

   // Partial sum for this iteration, including the carry out of the upper half.
   assign sum  = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
   assign full = {acc, mplier};

   assign bus.busy_o = busy;
   assign bus.done_o = done;
   assign bus.p_o    = p;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         p      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
                  mcand  <= (bus.signed_i && bus.a_i[W-1]) ? -bus.a_i : bus.a_i;
                  mplier <= (bus.signed_i && bus.b_i[W-1]) ? -bus.b_i : bus.b_i;
                  neg    <= bus.signed_i & (bus.a_i[W-1] ^ bus.b_i[W-1]);
                  acc    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= sum[W:1];
               mplier <= {sum[0], mplier[W-1:1]};
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(W - 1)) begin
                  state <= FIN;
               end
            end
            FIN: begin
               p     <= neg ? -full : full;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_mult_n.sv
// Self-checking bench: directed W=16 cases, reset abort and back-to-back starts,
// plus randomized W=8 operations checked against an arithmetic reference.
module tb_seq_mult_n;
   logic clk;
   logic rst16;
   logic rst8;
   int   errors;
   int   checks;

   seq_mult_n_if #(.W(16)) bus16 ();
   seq_mult_n_if #(.W(8))  bus8 ();

   seq_mult_n #(.W(16)) dut16 (.clk_i(clk), .rst_i(rst16), .bus(bus16));
   seq_mult_n #(.W(8))  dut8  (.clk_i(clk), .rst_i(rst8),  .bus(bus8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Exact product computed from the operand values themselves.
   function automatic longint refMul(bit sgn, int w, longint a, longint b);
      longint x;
      longint y;
      x = a;
      y = b;
      if (sgn && x[w-1]) x = x - (longint'(1) << w);
      if (sgn && y[w-1]) y = y - (longint'(1) << w);
      return (x * y) & ((longint'(1) << (2 * w)) - 1);
   endfunction

   task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus16(bit sgn, logic [15:0] a, logic [15:0] b);
      bus16.start_i  = 1'b1;
      bus16.signed_i = sgn;
      bus16.a_i      = a;
      bus16.b_i      = b;
      @(posedge clk);
      #1;
      bus16.start_i  = 1'b0;
   endtask

   task automatic waitDone16(output int lat, output int busyCycles);
      lat = 0;
      busyCycles = 0;
      while (!bus16.done_o && lat < 60) begin
         if (bus16.busy_o) busyCycles++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic applyStimulus8(bit sgn, logic [7:0] a, logic [7:0] b);
      bus8.start_i  = 1'b1;
      bus8.signed_i = sgn;
      bus8.a_i      = a;
      bus8.b_i      = b;
      @(posedge clk);
      #1;
      bus8.start_i  = 1'b0;
   endtask

   task automatic waitDone8(output int lat);
      lat = 0;
      while (!bus8.done_o && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int bc;
      int pulses;
      bit sgn;
      logic [7:0] ra;
      logic [7:0] rb;

      errors = 0;
      checks = 0;
      rst16 = 1'b1;
      rst8  = 1'b1;
      bus16.start_i = 1'b0; bus16.signed_i = 1'b0; bus16.a_i = '0; bus16.b_i = '0;
      bus8.start_i  = 1'b0; bus8.signed_i  = 1'b0; bus8.a_i  = '0; bus8.b_i  = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy16", 64'(bus16.busy_o), 64'd0);
      checkOutput("reset_done16", 64'(bus16.done_o), 64'd0);
      checkOutput("reset_p16",    64'(bus16.p_o),    64'd0);
      checkOutput("reset_p8",     64'(bus8.p_o),     64'd0);
      rst16 = 1'b0;
      rst8  = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] unsigned max operands");
      applyStimulus16(1'b0, 16'hFFFF, 16'hFFFF);
      waitDone16(lat, bc);
      checkOutput("umax_p",       64'(bus16.p_o),    64'hFFFE0001);
      checkOutput("umax_latency", 64'(lat),          64'd17);
      checkOutput("umax_busy",    64'(bc),           64'd17);
      checkOutput("umax_busylow", 64'(bus16.busy_o), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("umax_done_one_cycle", 64'(bus16.done_o), 64'd0);

      $display("[TB] signed directed cases");
      applyStimulus16(1'b1, 16'hFFFD, 16'h0005);
      waitDone16(lat, bc);
      checkOutput("s_m3x5", 64'(bus16.p_o), 64'hFFFFFFF1);
      applyStimulus16(1'b1, 16'hFFFF, 16'hFFFF);
      waitDone16(lat, bc);
      checkOutput("s_m1xm1", 64'(bus16.p_o), 64'h00000001);
      applyStimulus16(1'b1, 16'h8000, 16'h8000);
      waitDone16(lat, bc);
      checkOutput("s_minxmin", 64'(bus16.p_o), 64'h40000000);
      applyStimulus16(1'b1, 16'h8000, 16'h0001);
      waitDone16(lat, bc);
      checkOutput("s_minx1", 64'(bus16.p_o), 64'hFFFF8000);
      checkOutput("s_minx1_latency", 64'(lat), 64'd17);
      applyStimulus16(1'b0, 16'h0000, 16'h1234);
      waitDone16(lat, bc);
      checkOutput("zero_p",       64'(bus16.p_o), 64'd0);
      checkOutput("zero_latency", 64'(lat),       64'd17);

      $display("[TB] start held through RUN with changing operands");
      bus16.start_i = 1'b1; bus16.signed_i = 1'b0; bus16.a_i = 16'd7; bus16.b_i = 16'd9;
      @(posedge clk);
      #1;
      bus16.a_i = 16'd100;
      bus16.b_i = 16'd100;
      bus16.signed_i = 1'b1;
      waitDone16(lat, bc);
      bus16.start_i = 1'b0;
      checkOutput("held_p",       64'(bus16.p_o), 64'd63);
      checkOutput("held_latency", 64'(lat),       64'd17);
      pulses = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (bus16.done_o) pulses++;
      end
      checkOutput("held_extra_done", 64'(pulses), 64'd0);

      $display("[TB] back-to-back starts");
      applyStimulus16(1'b0, 16'd3, 16'd4);
      waitDone16(lat, bc);
      checkOutput("b2b_first_p", 64'(bus16.p_o), 64'd12);
      applyStimulus16(1'b0, 16'd12, 16'd12);
      checkOutput("b2b_accepted", 64'(bus16.busy_o), 64'd1);
      checkOutput("b2b_hold_p",   64'(bus16.p_o),    64'd12);
      waitDone16(lat, bc);
      checkOutput("b2b_second_p",   64'(bus16.p_o), 64'd144);
      checkOutput("b2b_second_lat", 64'(lat),       64'd17);

      $display("[TB] reset during RUN");
      applyStimulus16(1'b0, 16'd5, 16'd6);
      repeat (7) @(posedge clk);
      #1;
      checkOutput("mid_busy_before", 64'(bus16.busy_o), 64'd1);
      rst16 = 1'b1;
      @(posedge clk);
      #1;
      rst16 = 1'b0;
      checkOutput("rst_busy", 64'(bus16.busy_o), 64'd0);
      checkOutput("rst_done", 64'(bus16.done_o), 64'd0);
      checkOutput("rst_p",    64'(bus16.p_o),    64'd0);
      pulses = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (bus16.done_o) pulses++;
      end
      checkOutput("rst_no_done", 64'(pulses), 64'd0);
      applyStimulus16(1'b0, 16'd11, 16'd13);
      waitDone16(lat, bc);
      checkOutput("post_rst_p",   64'(bus16.p_o), 64'd143);
      checkOutput("post_rst_lat", 64'(lat),       64'd17);

      $display("[TB] randomized W=8 operations");
      for (int i = 0; i < 1000; i++) begin
         sgn = 1'($urandom);
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         if (i == 0) begin ra = 8'h80; rb = 8'h80; sgn = 1'b1; end
         if (i == 1) begin ra = 8'hFF; rb = 8'hFF; sgn = 1'b0; end
         applyStimulus8(sgn, ra, rb);
         waitDone8(lat);
         checkOutput("rand8_p", 64'(bus8.p_o),
                     64'(refMul(sgn, 8, longint'(ra), longint'(rb))));
         checkOutput("rand8_latency", 64'(lat), 64'd9);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
